// File: rtl/li_expander.sv
// li_expander -- load-immediate expander.
//
// Turns (rd, 32-bit constant) requests into the shortest RV32I sequence that
// materialises the constant in rd: a single ADDI, a single LUI, or LUI+ADDI.
// A request to x0 produces the canonical NOP.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake
//   in_rd, in_value      destination register and constant (sampled on accept)
//   out_valid/out_ready  instruction-word handshake
//   out_instr            encoded instruction word (registered)
//   out_last             final word of the current sequence (registered)
//   err                  sticky self-check mismatch
//
// Build option
//   LI_EXPANDER_CHECK_EN  when defined, an accumulator replays the emitted words
//                         and sets err if they do not rebuild the captured
//                         value. When undefined, err is tied to 0.
//
// Only DATA_WIDTH == 32 is supported; the field slicing below assumes RV32.

module li_expander #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_rd,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  out_last,
  output logic                  err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EMIT_A = 2'd1;
  localparam logic [1:0] EMIT_B = 2'd2;

  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_LUI = 7'b0110111;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [1:0]  state;
  logic [31:0] pend_instr;   // second word of a LUI+ADDI pair

  logic fire, accept;

  assign fire     = out_valid & out_ready;
  assign in_ready = (state == IDLE) | (fire & out_last);
  assign accept   = in_valid & in_ready;

  // Request decode, evaluated on the raw inputs so the first word can be
  // registered in the accept cycle.
  logic [11:0] lo;
  logic [19:0] hi;
  logic        fits_i;
  logic [31:0] first_w, second_w;
  logic        first_last;

  assign lo = in_value[11:0];
  // ADDI sign-extends lo, so a negative lo borrows one from the upper part;
  // rounding hi up compensates. The add wraps mod 2^20 by design.
  assign hi = in_value[31:12] + {19'd0, in_value[11]};
  assign fits_i = (in_value[31:0] == {{20{lo[11]}}, lo});

  always_comb begin
    first_w    = NOP;
    second_w   = NOP;
    first_last = 1'b1;
    if (in_rd == 5'd0) begin
      first_w = NOP;
    end else if (fits_i) begin
      first_w = {lo, 5'd0, 3'b000, in_rd, OP_IMM};
    end else if (lo == 12'd0) begin
      first_w = {hi, in_rd, OP_LUI};
    end else begin
      first_w    = {hi, in_rd, OP_LUI};
      second_w   = {lo, in_rd, 3'b000, in_rd, OP_IMM};
      first_last = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_last   <= 1'b0;
      pend_instr <= '0;
    end else if (accept) begin
      // Covers both the idle accept and the accept that overlaps the
      // last-beat handshake of the previous sequence.
      state      <= EMIT_A;
      out_valid  <= 1'b1;
      out_instr  <= first_w;
      out_last   <= first_last;
      pend_instr <= second_w;
    end else begin
      case (state)
        EMIT_A: begin
          if (fire) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              state     <= EMIT_B;
              out_instr <= pend_instr;
              out_last  <= 1'b1;
            end
          end
        end
        EMIT_B: begin
          if (fire) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LI_EXPANDER_CHECK_EN
  // Replays each handshaken word into an accumulator that models the
  // architectural value of rd.
  logic [31:0] cap_value;
  logic [31:0] acc, acc_nxt;
  logic [31:0] imm_sext;
  logic        err_q;

  assign imm_sext = {{20{out_instr[31]}}, out_instr[31:20]};

  always_comb begin
    acc_nxt = acc;
    if (out_instr[6:0] == OP_LUI)
      acc_nxt = {out_instr[31:12], 12'd0};
    else if (out_instr[6:0] == OP_IMM) begin
      if (out_instr[19:15] == 5'd0) acc_nxt = imm_sext;
      else                          acc_nxt = acc + imm_sext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_value <= '0;
      acc       <= '0;
      err_q     <= 1'b0;
    end else begin
      if (fire) begin
        acc <= acc_nxt;
        // cap_value still holds the finishing request here, even when a new
        // request is accepted in the same cycle.
        if (out_last && (out_instr != NOP) && (acc_nxt != cap_value))
          err_q <= 1'b1;
      end
      if (accept) cap_value <= in_value[31:0];
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/li_expander.md
# li_expander

Load-immediate expander for the instruction-generation path. Accepts a destination register and a 32-bit constant, then emits the minimal RV32I sequence that materialises it: `ADDI` alone, `LUI` alone, or `LUI`+`ADDI`. This is the inverse of the immediate sign-extension stage: that stage recovers values from instruction words, while this block produces instruction words from values. It sits between the test/program generator and the instruction memory writer, using valid/ready on both sides.

## Interface

- `DATA_WIDTH`, default 32, instruction and value width; only 32 is supported.

- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — request valid.
- `in_ready` output 1 — request accepted this cycle when `in_valid && in_ready`.
- `in_rd` input 5 — destination register index.
- `in_value` input DATA_WIDTH — constant to load.
- `out_valid` output 1 — `out_instr` holds a valid instruction word.
- `out_ready` input 1 — consumer accepts the word.
- `out_instr` output DATA_WIDTH — encoded instruction.
- `out_last` output 1 — marks the final word of the current sequence.
- `err` output 1 — sticky self-check mismatch; see Configuration.

## Operation

- **FSM states:** IDLE, EMIT_A, EMIT_B.
- **Request capture:** on accept, the block captures `rd`, `value`, `lo = value[11:0]`, and `hi = value[31:12] + value[11]` (20-bit, mod 2^20).
- **Sequence selection:**
  - `rd == 0`: single canonical NOP `0x00000013`, with `out_last=1`.
  - `value` equals the sign-extension of `lo`: single `ADDI rd, x0, lo`, with `out_last=1`.
  - Else if `lo == 0`: single `LUI rd, hi`, with `out_last=1`.
  - Else: `LUI rd, hi` with `out_last=0`, followed by `ADDI rd, rd, lo` with `out_last=1`.
- **Encodings:**
  - `ADDI` = {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - `LUI` = {imm[19:0], rd, 7'b0110111}.
- **Wrap-around:** the `hi` increment may wrap. Example: `0x7FFFF800` gives `LUI 0x80000`, then `ADDI -2048`. No error is raised for this case.
- **State transitions:**
  - IDLE → EMIT_A on accept.
  - EMIT_A → IDLE when `out_valid && out_ready && out_last`.
  - EMIT_A → EMIT_B when `out_valid && out_ready && !out_last`.
  - EMIT_B → IDLE on output handshake.
- **Back-to-back requests:** `in_ready = (state==IDLE) | (out_valid & out_ready & out_last)`. An accept on the last-beat handshake goes directly to EMIT_A with the new request.

## Timing

- **Reset values:** `out_valid=0`, `out_instr=0`, `out_last=0`, `err=0`, state IDLE. Consequently `in_ready=1` while in reset.
- **Latency:** the first word is valid one cycle after accept. The second word is valid the cycle after the first word's handshake.
- **Throughput:** with `out_ready` held high, one word per cycle. A two-word request occupies 2 cycles, with no bubble between requests.
- **Output stability:** `out_instr` and `out_last` are registered and hold stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake.
- **Input capture:** `in_value` and `in_rd` are sampled only on accept. Later changes to them have no effect.
- **Reset mid-sequence:** immediately clears `out_valid`. The pending second word is discarded and the state returns to IDLE.

## Configuration

- **`LI_EXPANDER_CHECK_EN` defined:**
  - An internal accumulator rebuilds the loaded value from the emitted words: `LUI` sets `imm<<12`, `ADDI` from x0 sets sext(imm), `ADDI` from rd adds sext(imm), and NOP skips the check.
  - On each last-beat handshake the accumulator is compared with the captured value.
  - A mismatch sets `err`, which stays set until reset.
- **Undefined:** no checker logic is built and `err` is tied to 0.

## Test plan

- **Single ADDI, positive:** `rd=5`, `value=0x000007FF` → one word `0x7FF00293`, `out_last=1`, first word one cycle after accept.
- **Single ADDI, negative boundary:** `rd=1`, `value=0xFFFFF800` → one word `0x80000093`, `out_last=1`.
- **Two-word sequences:**
  - `rd=10`, `value=0x12345678` → `0x12345537` (`last=0`), then `0x67850513` (`last=1`).
  - `rd=2`, `value=0x00000800` → `0x00001137`, then `0x80010113`, exercising the `hi` round-up.
- **LUI-only and NOP cases:**
  - `rd=3`, `value=0xABCDE000` → single `0xABCDE1B7`, `last=1`.
  - `rd=0`, any value → single `0x00000013`.
- **Backpressure and back-to-back:**
  - Hold `out_ready=0` for 3 cycles during the `0x12345678` sequence → `out_instr` stays stable.
  - Then present a new request with `out_ready=1` → it is accepted on the last-beat handshake, with no idle cycle.
- **Reset mid-sequence and checker:**
  - Deassert `rst_n` after the first `LUI` word → `out_valid=0` asynchronously and `in_ready=1`.
  - With `LI_EXPANDER_CHECK_EN`, run 1000 random values → `err` stays 0.
